// File: rtl/mem_port_arbiter.sv
// Shares the single RAM port between instruction fetch and the load/store path.
// Round-robin grant, MFA/MOC handshake, timeout abort and per-owner completion pulses.
//
// state  | meaning
// S_IDLE | no access in flight, arbitrate pending requests
// S_WAIT | MFA high, waiting for MOC or timeout
// S_DONE | one-cycle successful completion pulse to owner
// S_ERR  | one-cycle completion pulse with error (misalign, bad size, timeout)
module mem_port_arbiter #(
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 15
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_if_req,
   input  logic [ADDR_W-1:0] i_if_addr,
   output logic              o_if_done,
   input  logic              i_du_req,
   input  logic              i_du_rw,
   input  logic [1:0]        i_du_size,
   input  logic [ADDR_W-1:0] i_du_addr,
   input  logic [31:0]       i_du_wdata,
   output logic              o_du_done,
   output logic              o_du_err,
   output logic [31:0]       o_rdata,
   output logic              o_mfa,
   output logic              o_rw,
   output logic [1:0]        o_size,
   output logic [ADDR_W-1:0] o_addr,
   output logic [31:0]       o_data_in,
   input  logic [31:0]       i_data_out,
   input  logic              i_moc
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_ERR} state_t;

   localparam logic              GNT_IF       = 1'b0;
   localparam logic              GNT_DU       = 1'b1;
   localparam logic [7:0]        LP_TC        = 8'(TIMEOUT - 1);
   localparam logic [ADDR_W-1:0] LP_WORD_MASK = ~ADDR_W'(3);

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_last_grant;
   logic              r_owner;
   logic [7:0]        r_cnt;
   logic              r_rw;
   logic [1:0]        r_size;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_data_in;
   logic [31:0]       r_rdata;

   logic              w_grant;
   logic              w_grant_du;
   logic              w_du_bad;
   logic [ADDR_W-1:0] w_if_addr;

   assign w_if_addr = i_if_addr & LP_WORD_MASK;
   assign w_du_bad  = (i_du_size == 2'b11)
                   || ((i_du_size == 2'b01) && i_du_addr[0])
                   || ((i_du_size == 2'b10) && (i_du_addr[1:0] != 2'b00));

   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      w_grant_du  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_if_req || i_du_req) begin
               w_grant    = 1'b1;
               // on a tie the requester that did not win last time gets the port
               w_grant_du = i_du_req && (!i_if_req || (r_last_grant == GNT_IF));
               w_state_nxt = (w_grant_du && w_du_bad) ? S_ERR : S_WAIT;
            end
         end
         S_WAIT: begin
            if (i_moc)
               w_state_nxt = S_DONE;
            else if (r_cnt == LP_TC)
               w_state_nxt = S_ERR;
         end
         S_DONE:  w_state_nxt = S_IDLE;
         S_ERR:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= S_IDLE;
         r_last_grant <= GNT_DU;
         r_owner      <= GNT_IF;
         r_cnt        <= 8'd0;
         r_rw         <= 1'b1;
         r_size       <= 2'b10;
         r_addr       <= '0;
         r_data_in    <= 32'd0;
         r_rdata      <= 32'd0;
      end else begin
         r_state <= w_state_nxt;
         if (w_grant) begin
            r_last_grant <= w_grant_du;
            r_owner      <= w_grant_du;
            r_cnt        <= 8'd0;
            if (!w_grant_du) begin
               r_rw   <= 1'b1;
               r_size <= 2'b10;
               r_addr <= w_if_addr;
            end else if (!w_du_bad) begin
               r_rw      <= i_du_rw;
               r_size    <= i_du_size;
               r_addr    <= i_du_addr;
               r_data_in <= i_du_wdata;
            end
         end
         if (r_state == S_WAIT) begin
            r_cnt <= r_cnt + 8'd1;
            if (i_moc && r_rw)
               r_rdata <= i_data_out;
         end
      end
   end

   assign o_mfa     = (r_state == S_WAIT);
   assign o_if_done = ((r_state == S_DONE) || (r_state == S_ERR)) && (r_owner == GNT_IF);
   assign o_du_done = ((r_state == S_DONE) || (r_state == S_ERR)) && (r_owner == GNT_DU);
   assign o_du_err  = (r_state == S_ERR) && (r_owner == GNT_DU);
   assign o_rw      = r_rw;
   assign o_size    = r_size;
   assign o_addr    = r_addr;
   assign o_data_in = r_data_in;
   assign o_rdata   = r_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: arbitration, fetch/load/store handshakes,
// alignment errors, timeout abort and reset during an access.
module tb_mem_port_arbiter;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        i_if_req;
   logic [7:0]  i_if_addr;
   logic        o_if_done;
   logic        i_du_req;
   logic        i_du_rw;
   logic [1:0]  i_du_size;
   logic [7:0]  i_du_addr;
   logic [31:0] i_du_wdata;
   logic        o_du_done;
   logic        o_du_err;
   logic [31:0] o_rdata;
   logic        o_mfa;
   logic        o_rw;
   logic [1:0]  o_size;
   logic [7:0]  o_addr;
   logic [31:0] o_data_in;
   logic [31:0] i_data_out;
   logic        i_moc;

   int n_tests = 0;
   int n_fail  = 0;

   mem_port_arbiter #(.ADDR_W(8), .TIMEOUT(15)) dut (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_if_req   (i_if_req),
      .i_if_addr  (i_if_addr),
      .o_if_done  (o_if_done),
      .i_du_req   (i_du_req),
      .i_du_rw    (i_du_rw),
      .i_du_size  (i_du_size),
      .i_du_addr  (i_du_addr),
      .i_du_wdata (i_du_wdata),
      .o_du_done  (o_du_done),
      .o_du_err   (o_du_err),
      .o_rdata    (o_rdata),
      .o_mfa      (o_mfa),
      .o_rw       (o_rw),
      .o_size     (o_size),
      .o_addr     (o_addr),
      .o_data_in  (o_data_in),
      .i_data_out (i_data_out),
      .i_moc      (i_moc)
   );

   always #5 i_clk = ~i_clk;

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      int n_hi;
      logic [1:0] bad_size [3];
      logic [7:0] bad_addr [3];
      bad_size[0] = 2'b10; bad_addr[0] = 8'h06;
      bad_size[1] = 2'b01; bad_addr[1] = 8'h05;
      bad_size[2] = 2'b11; bad_addr[2] = 8'h00;

      i_reset = 1'b1; i_if_req = 1'b0; i_if_addr = 8'h00;
      i_du_req = 1'b0; i_du_rw = 1'b1; i_du_size = 2'b10; i_du_addr = 8'h00;
      i_du_wdata = 32'h0; i_data_out = 32'h0; i_moc = 1'b0;
      step(); step();
      chk("rst_mfa",     o_mfa, 1'b0);
      chk("rst_rw",      o_rw, 1'b1);
      chk("rst_size",    o_size, 2'b10);
      chk("rst_addr",    o_addr, 8'h00);
      chk("rst_datain",  o_data_in, 32'h0);
      chk("rst_rdata",   o_rdata, 32'h0);
      chk("rst_if_done", o_if_done, 1'b0);
      chk("rst_du_done", o_du_done, 1'b0);
      chk("rst_du_err",  o_du_err, 1'b0);
      i_reset = 1'b0;
      step();

      // both requesters held high: grants must alternate IF, DU, IF, DU
      i_if_req = 1'b1; i_if_addr = 8'h20;
      i_du_req = 1'b1; i_du_rw = 1'b1; i_du_size = 2'b10; i_du_addr = 8'h40;
      i_data_out = 32'hA5A5_0001;
      for (int g = 0; g < 4; g++) begin
         step();
         chk("rr_mfa",  o_mfa, 1'b1);
         chk("rr_addr", o_addr, (g % 2 == 0) ? 8'h20 : 8'h40);
         i_moc = 1'b1;
         step();
         chk("rr_if_done", o_if_done, (g % 2 == 0) ? 1'b1 : 1'b0);
         chk("rr_du_done", o_du_done, (g % 2 == 0) ? 1'b0 : 1'b1);
         i_moc = 1'b0;
         if (g == 3) begin
            i_if_req = 1'b0;
            i_du_req = 1'b0;
         end
         step();
         chk("rr_idle_mfa", o_mfa, 1'b0);
      end
      chk("rr_rdata", o_rdata, 32'hA5A5_0001);

      // fetch with unaligned address, MOC in the second WAIT cycle
      i_if_req = 1'b1; i_if_addr = 8'h07; i_data_out = 32'hE3A0_1005;
      step();
      chk("f_mfa",  o_mfa, 1'b1);
      chk("f_addr", o_addr, 8'h04);
      chk("f_rw",   o_rw, 1'b1);
      chk("f_size", o_size, 2'b10);
      i_if_req = 1'b0;
      step();
      chk("f_wait2_mfa",  o_mfa, 1'b1);
      chk("f_wait2_done", o_if_done, 1'b0);
      i_moc = 1'b1;
      step();
      chk("f_done",    o_if_done, 1'b1);
      chk("f_du_done", o_du_done, 1'b0);
      chk("f_mfa_off", o_mfa, 1'b0);
      chk("f_rdata",   o_rdata, 32'hE3A0_1005);
      i_moc = 1'b0;
      step();
      chk("f_done_1cyc", o_if_done, 1'b0);

      // halfword store; address change during WAIT must be ignored
      i_du_req = 1'b1; i_du_rw = 1'b0; i_du_size = 2'b01; i_du_addr = 8'h12;
      i_du_wdata = 32'h0000_BEEF; i_data_out = 32'hDEAD_DEAD;
      step();
      chk("st_mfa",    o_mfa, 1'b1);
      chk("st_rw",     o_rw, 1'b0);
      chk("st_size",   o_size, 2'b01);
      chk("st_addr",   o_addr, 8'h12);
      chk("st_datain", o_data_in, 32'h0000_BEEF);
      i_du_req = 1'b0; i_du_addr = 8'h99; i_du_wdata = 32'h1234_0000;
      i_moc = 1'b1;
      step();
      chk("st_done",     o_du_done, 1'b1);
      chk("st_err",      o_du_err, 1'b0);
      chk("st_if_done",  o_if_done, 1'b0);
      chk("st_rdata",    o_rdata, 32'hE3A0_1005);
      chk("st_addr_hold", o_addr, 8'h12);
      i_moc = 1'b0;
      step();
      chk("st_done_1cyc", o_du_done, 1'b0);

      // misaligned word, misaligned halfword, reserved size
      for (int b = 0; b < 3; b++) begin
         i_du_req = 1'b1; i_du_rw = 1'b1; i_du_size = bad_size[b]; i_du_addr = bad_addr[b];
         step();
         chk("mis_mfa",  o_mfa, 1'b0);
         chk("mis_done", o_du_done, 1'b1);
         chk("mis_err",  o_du_err, 1'b1);
         i_du_req = 1'b0;
         step();
         chk("mis_idle_done", o_du_done, 1'b0);
         chk("mis_idle_mfa",  o_mfa, 1'b0);
      end

      // load with MOC never arriving
      i_du_req = 1'b1; i_du_rw = 1'b1; i_du_size = 2'b10; i_du_addr = 8'h20;
      i_data_out = 32'h1234_5678; i_moc = 1'b0;
      step();
      chk("to_mfa", o_mfa, 1'b1);
      i_du_req = 1'b0;
      n_hi = 1;
      for (int c = 0; c < 14; c++) begin
         step();
         if (o_mfa) n_hi++;
      end
      step();
      chk("to_wait_cycles", n_hi, 15);
      chk("to_mfa_off", o_mfa, 1'b0);
      chk("to_done",    o_du_done, 1'b1);
      chk("to_err",     o_du_err, 1'b1);
      chk("to_rdata",   o_rdata, 32'hE3A0_1005);
      step();
      chk("to_idle_done", o_du_done, 1'b0);

      // reset in the third WAIT cycle of a fetch
      i_if_req = 1'b1; i_if_addr = 8'h30;
      step();
      i_if_req = 1'b0;
      step();
      step();
      chk("rw_wait3_mfa", o_mfa, 1'b1);
      i_reset = 1'b1;
      step();
      chk("rw_mfa",     o_mfa, 1'b0);
      chk("rw_if_done", o_if_done, 1'b0);
      chk("rw_addr",    o_addr, 8'h00);
      chk("rw_rdata",   o_rdata, 32'h0);
      i_reset = 1'b0;
      step();
      chk("rw_no_pulse", o_if_done, 1'b0);
      chk("rw_idle_mfa", o_mfa, 1'b0);
      i_if_req = 1'b1; i_du_req = 1'b1; i_du_addr = 8'h40;
      step();
      chk("rw_tie_addr", o_addr, 8'h30);
      i_if_req = 1'b0; i_du_req = 1'b0; i_moc = 1'b1;
      step();
      chk("rw_tie_done", o_if_done, 1'b1);
      i_moc = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single RAM port between the instruction-fetch path and the data (load/store) path.
- Arbitrates the two requesters round-robin and runs the MFA/MOC handshake with the RAM.
- Returns read data, a completion pulse and an error flag to the winning requester.
- The control unit's fetch and load/store states issue requests here instead of driving the RAM directly.

Parameters:
- ADDR_W, 8, RAM byte-address width.
- TIMEOUT, 15, maximum WAIT cycles without MOC before the access is aborted with an error (1..255).

Ports:
- Clk  input  1  clock; all logic is on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- if_req  input  1  fetch request, level.
- if_addr  input  ADDR_W  fetch address; bits [1:0] are ignored and forced to 00.
- if_done  output  1  one-cycle completion pulse to fetch.
- du_req  input  1  data request, level.
- du_rw  input  1  1 = read (load), 0 = write (store).
- du_size  input  2  00 byte, 01 halfword, 10 word; 11 is treated as an error.
- du_addr  input  ADDR_W  data address.
- du_wdata  input  32  store data.
- du_done  output  1  one-cycle completion pulse to the data path.
- du_err  output  1  valid with du_done: misaligned access, size 11, or timeout.
- rdata  output  32  read data; updated only on a successful read and held otherwise.
- MFA  output  1  memory function active, to RAM.
- RW  output  1  to RAM: 1 read, 0 write.
- Size  output  2  to RAM.
- Addr  output  ADDR_W  to RAM.
- DataIn  output  32  write data to RAM.
- DataOut  input  32  read data from RAM.
- MOC  input  1  memory operation complete, from RAM.

Behaviour:
- Reset values: MFA=0, RW=1, Size=10, Addr=0, DataIn=0, rdata=0, if_done=0, du_done=0, du_err=0, state=IDLE, last_grant=DU (fetch wins the first tie), wait counter=0.
- States: IDLE, WAIT, DONE, ERR.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant it.
  - Both requesting: grant the requester not equal to last_grant; last_grant updates on grant.
  - Fetch grant: register RW=1, Size=10, Addr={if_addr[ADDR_W-1:2],00}, assert MFA, go to WAIT.
  - DU grant, misaligned (halfword with addr[0]=1, word with addr[1:0]≠0) or size 11: no RAM access, MFA stays 0, go to ERR.
  - DU grant, otherwise: register RW=du_rw, Size=du_size, Addr=du_addr, DataIn=du_wdata, assert MFA, go to WAIT.
- WAIT:
  - MFA=1 and Addr/RW/Size/DataIn held stable.
  - The counter increments each WAIT cycle.
  - MOC=1: if RW=1, capture DataOut into rdata; drop MFA; go to DONE.
  - MOC=0 with counter==TIMEOUT−1: drop MFA, rdata unchanged, go to ERR.
- DONE: pulse the owner's done for exactly one cycle with du_err=0, then go to IDLE.
- ERR: pulse the owner's done for one cycle with du_err=1 (a fetch timeout also pulses if_done; du_err stays 0 for fetch owner), then go to IDLE.
- Latency: request sampled in IDLE in cycle 0 → MFA high in cycle 1 → MOC first seen in cycle k≥1 → done in cycle k+1. Minimum is 3 cycles from request to done, and at least one IDLE cycle separates accesses.
- Requests are level-sensitive. A req still high in the IDLE cycle after done starts a new access, so requesters drop req on seeing done.
- Inputs are sampled only at grant. Address or data changes during WAIT are ignored.
- MOC while in IDLE, DONE or ERR is ignored.
- if_done and du_done are never high in the same cycle.
- Reset in any state (including WAIT with MFA=1) returns every output to its reset value at the next edge. The pending access is abandoned with no done pulse.

Test Plan:
- Fetch read, if_addr=0x07, MOC high in the 2nd WAIT cycle, DataOut=0xE3A01005 → Addr=0x04, RW=1, Size=10; if_done one cycle at request+4; rdata=0xE3A01005.
- if_req and du_req both high out of reset → fetch granted first; du_req still high → DU granted next (Addr=du_addr); then both again → fetch (alternation verified over 4 grants).
- DU store, size 01, addr 0x12, wdata 0x0000BEEF → MFA with RW=0, Size=01, DataIn=0x0000BEEF; du_done, du_err=0; rdata unchanged.
- DU word access at addr 0x06 → MFA never asserts; du_done and du_err=1 at request+2. Halfword at 0x05 and size 11 give the same result.
- MOC held 0 for a DU read → MFA drops after exactly 15 WAIT cycles; du_done and du_err=1 next cycle; rdata keeps its previous value.
- Reset asserted in the 3rd WAIT cycle → MFA=0 at the next edge, no done pulse, IDLE; a later fetch tie-break goes to fetch.
